// File: rtl/seq_alu_mdu_if.sv
// Issue/result handshake bundle for seq_alu_mdu: operands and op in, registered result and flags out.
interface seq_alu_mdu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       Op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Y;
  logic             Overflow;
  logic             Zero;
  logic             Illegal;

  // Both sides use valid/ready: a transfer happens on the rising clk edge where
  // valid and ready are both high; the sender holds its payload steady until then.
  modport master (
    output in_valid, A, B, Op, out_ready,
    input  in_ready, out_valid, Y, Overflow, Zero, Illegal
  );

  modport slave (
    input  in_valid, A, B, Op, out_ready,
    output in_ready, out_valid, Y, Overflow, Zero, Illegal
  );
endinterface

// File: rtl/seq_alu_mdu.sv
// Multi-cycle ALU: one-cycle base ops plus iterative unsigned MUL/MULHU/DIVU/REMU.
// The iterative unit exists only when SEQ_ALU_MULDIV_EN is defined; otherwise ops 1000-1011 are illegal.
module seq_alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  seq_alu_mdu_if.slave       bus,
  output logic [1:0]         dbg_state
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

`ifdef SEQ_ALU_MULDIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1, ITER = 2'd2} state_t;
  localparam int CW = $clog2(WIDTH);
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             ovf_q, ovf_d, zero_q, zero_d, ill_q, ill_d;

  logic [WIDTH-1:0] base_y, sum, diff;
  logic             base_ovf, base_ill;

`ifdef SEQ_ALU_MULDIV_EN
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [1:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   mul_sum, div_sh, div_df;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             is_md;
`endif

  always_comb begin
    sum      = bus.A + bus.B;
    diff     = bus.A - bus.B;
    base_y   = '0;
    base_ovf = 1'b0;
    base_ill = 1'b0;
    case (bus.Op)
      OP_AND: base_y = bus.A & bus.B;
      OP_OR:  base_y = bus.A | bus.B;
      OP_ADD: begin
        base_y   = sum;
        base_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        base_y   = diff;
        base_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
      end
      // Direct signed compare, so an overflowing A-B cannot flip the answer.
      OP_SLT: base_y = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OP_NOR: base_y = ~(bus.A | bus.B);
      default: base_ill = 1'b1;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  assign is_md = (bus.Op[3:2] == 2'b10);

  // hi/lo hold {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_sh  = {hi_q, lo_q[WIDTH-1]};
    div_df  = div_sh - {1'b0, opnd_q};
    if (op_q[1]) begin
      if (!div_df[WIDTH]) begin
        step_hi = div_df[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_sh[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
`ifdef SEQ_ALU_MULDIV_EN
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
`ifdef SEQ_ALU_MULDIV_EN
          if (is_md) begin
            state_d = ITER;
            cnt_d   = '0;
            op_d    = bus.Op[1:0];
            hi_d    = '0;
            opnd_d  = bus.Op[1] ? bus.B : bus.A;
            lo_d    = bus.Op[1] ? bus.A : bus.B;
          end else
`endif
          begin
            state_d = DONE;
            y_d     = base_y;
            ovf_d   = base_ovf;
            zero_d  = (base_y == '0);
            ill_d   = base_ill;
          end
        end
      end
`ifdef SEQ_ALU_MULDIV_EN
      ITER: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // op_q[0] selects the high half: MULHU and REMU.
          state_d = DONE;
          cnt_d   = '0;
          y_d     = op_q[0] ? step_hi : step_lo;
          ovf_d   = 1'b0;
          zero_d  = ((op_q[0] ? step_hi : step_lo) == '0);
          ill_d   = 1'b0;
        end
      end
`endif
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
`ifdef SEQ_ALU_MULDIV_EN
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.Y         = y_q;
  assign bus.Overflow  = ovf_q;
  assign bus.Zero      = zero_q;
  assign bus.Illegal   = ill_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_seq_alu_mdu.sv
// Bench for seq_alu_mdu (WIDTH=32): vector table, corner sequences, random ops vs a plain-arithmetic model.
module tb_seq_alu_mdu;
  localparam int W = 32;
`ifdef SEQ_ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [W-1:0] exp_q[$];

  seq_alu_mdu_if #(.WIDTH(W)) bus();
  seq_alu_mdu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    bit           ovf;
    bit           ill;
  } vec_t;
  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour from the arithmetic rules, using 64-bit integers.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] y, output bit ovf, output bit ill, output int lat);
    longint          sa, sb, s;
    longint unsigned p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = longint'(a) * longint'(b);
    y = '0; ovf = 1'b0; ill = 1'b0; lat = 1; s = 0;
    case (op)
      4'd0:  y = a & b;
      4'd1:  y = a | b;
      4'd2:  begin s = sa + sb; y = W'(s); ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd6:  begin s = sa - sb; y = W'(s); ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd7:  y = (sa < sb) ? 1 : 0;
      4'd12: y = ~(a | b);
      4'd8, 4'd9, 4'd10, 4'd11: begin
        if (MD) begin
          lat = W + 1;
          case (op)
            4'd8:    y = p[31:0];
            4'd9:    y = p[63:32];
            4'd10:   y = (b == 0) ? '1 : a / b;
            default: y = (b == 0) ? a : a % b;
          endcase
        end else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
  endfunction

  // Entered and left at #1 after a rising edge, with the unit idle.
  task automatic apply(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ey, input bit eovf, input bit eill, input int elat,
                       input int hold, input string name);
    int waitc;
    int lat;
    logic [W-1:0] qy;
    exp_q.push_back(ey);
    bus.Op = op; bus.A = a; bus.B = b; bus.in_valid = 1'b1; bus.out_ready = (hold == 0);
    waitc = 0;
    while (!bus.in_ready && waitc < 50) begin @(posedge clk); #1; waitc++; end
    check({name, " in_ready"}, bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    qy = exp_q.pop_front();
    check({name, " latency"}, lat, elat);
    check({name, " Y"}, bus.Y, qy);
    check({name, " Overflow"}, bus.Overflow, eovf);
    check({name, " Zero"}, bus.Zero, (qy == 0));
    check({name, " Illegal"}, bus.Illegal, eill);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({name, " hold out_valid"}, bus.out_valid, 1);
      check({name, " hold in_ready"}, bus.in_ready, 0);
      check({name, " hold Y"}, bus.Y, qy);
      check({name, " hold Zero"}, bus.Zero, (qy == 0));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check({name, " back to idle"}, bus.in_ready, 1);
    check({name, " out_valid drop"}, bus.out_valid, 0);
  endtask

  task automatic apply_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input int hold, input string name);
    logic [W-1:0] y;
    bit ovf, ill;
    int lat;
    model(op, a, b, y, ovf, ill, lat);
    apply(op, a, b, y, ovf, ill, lat, hold, name);
  endtask

  initial begin
    logic [3:0]   rop;
    logic [W-1:0] ra, rb;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.A = '0; bus.B = '0; bus.Op = '0;

    vecs[0]  = '{4'b0000, 32'd1, 32'd5, 32'd1, 1'b0, 1'b0};
    vecs[1]  = '{4'b0001, 32'd1, 32'd5, 32'd5, 1'b0, 1'b0};
    vecs[2]  = '{4'b0010, 32'd1, 32'd5, 32'd6, 1'b0, 1'b0};
    vecs[3]  = '{4'b0110, 32'd1, 32'd5, 32'hFFFFFFFC, 1'b0, 1'b0};
    vecs[4]  = '{4'b0111, 32'd1, 32'd5, 32'd1, 1'b0, 1'b0};
    vecs[5]  = '{4'b1100, 32'd1, 32'd5, 32'hFFFFFFFA, 1'b0, 1'b0};
    vecs[6]  = '{4'b0010, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b1, 1'b0};
    vecs[7]  = '{4'b0110, 32'd7, 32'd7, 32'd0, 1'b0, 1'b0};
    vecs[8]  = '{4'b0111, 32'h80000000, 32'd1, 32'd1, 1'b0, 1'b0};
    vecs[9]  = '{4'b0111, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0};
    vecs[10] = '{4'b0110, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b1, 1'b0};
    vecs[11] = '{4'b0010, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0};
    vecs[12] = '{4'b0011, 32'd4, 32'd9, 32'd0, 1'b0, 1'b1};
    vecs[13] = '{4'b1111, 32'hDEAD, 32'hBEEF, 32'd0, 1'b0, 1'b1};
    vecs[14] = '{4'b0000, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'd0, 1'b0, 1'b0};

    // Reset state
    #12;
    check("reset out_valid", bus.out_valid, 0);
    check("reset Y", bus.Y, 0);
    check("reset Zero", bus.Zero, 0);
    check("reset Illegal", bus.Illegal, 0);
    check("reset Overflow", bus.Overflow, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    check("post-reset in_ready", bus.in_ready, 1);

    for (int i = 0; i < 15; i++)
      apply(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].ovf, vecs[i].ill, 1, 0,
            $sformatf("vec%0d", i));

    // Iterative ops; in the default build the same codes are illegal with latency 1.
    if (MD) begin
      apply(4'b1000, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b0, 1'b0, W + 1, 0, "mul");
      apply(4'b1001, 32'hFFFFFFFF, 32'd2, 32'd1, 1'b0, 1'b0, W + 1, 0, "mulhu");
      apply(4'b1010, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, W + 1, 0, "divu");
      apply(4'b1011, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, W + 1, 0, "remu");
      apply(4'b1010, 32'h12345678, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, W + 1, 0, "divu by 0");
      apply(4'b1011, 32'd9, 32'd0, 32'd9, 1'b0, 1'b0, W + 1, 0, "remu by 0");
    end else begin
      apply(4'b1000, 32'hFFFFFFFF, 32'd2, 32'd0, 1'b0, 1'b1, 1, 0, "mul illegal");
      apply(4'b1011, 32'd9, 32'd0, 32'd0, 1'b0, 1'b1, 1, 0, "remu illegal");
    end

    // Consumer stalls for 5 cycles in DONE
    apply(4'b0010, 32'd40, 32'd2, 32'd42, 1'b0, 1'b0, 1, 5, "stall add");

    // Reset 10 cycles into a DIVU while the consumer is not ready
    bus.Op = 4'b1010; bus.A = 32'd1000; bus.B = 32'd3; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    check("rst seq accept", bus.in_ready, 1);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid-op reset out_valid", bus.out_valid, 0);
    check("mid-op reset Y", bus.Y, 0);
    check("mid-op reset Zero", bus.Zero, 0);
    check("mid-op reset Illegal", bus.Illegal, 0);
    @(posedge clk); #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    check("after reset in_ready", bus.in_ready, 1);
    apply(4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1, 0, "add after reset");
    apply(4'b0011, 32'd2, 32'd3, 32'd0, 1'b0, 1'b1, 1, 0, "op 0011");

    // Random ops against the model
    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      apply_model(rop, ra, rb, $urandom_range(0, 2), $sformatf("rand%0d op%0h", i, rop));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
